// File: rtl/spad_req_decoder_if.sv
// Bundles the request-FIFO, row-request and GEMM-command signals of the
// scratchpad request decoder into one port.
interface spad_req_decoder_if #(
    parameter int ROWS  = 4,
    parameter int IDX_W = $clog2(ROWS)
);
    // valid/ready: a transfer happens in a cycle where valid && ready. Once
    // valid rises it stays high with a stable payload until that transfer,
    // unless a flush or reset abandons the command.
    logic              fifo_empty;
    logic              fifo_ren;
    logic [42:0]       fifo_rdata;

    logic              row_valid;
    logic              row_ready;
    logic              row_load;
    logic [3:0]        row_matrix;
    logic [IDX_W-1:0]  row_idx;
    logic [31:0]       row_addr;
    logic              row_last;

    logic              gemm_valid;
    logic              gemm_ready;
    logic              gemm_new_weight;
    logic [15:0]       gemm_select;

    modport master (
        input  fifo_empty, fifo_rdata, row_ready, gemm_ready,
        output fifo_ren, row_valid, row_load, row_matrix, row_idx, row_addr,
               row_last, gemm_valid, gemm_new_weight, gemm_select
    );

    modport slave (
        output fifo_empty, fifo_rdata, row_ready, gemm_ready,
        input  fifo_ren, row_valid, row_load, row_matrix, row_idx, row_addr,
               row_last, gemm_valid, gemm_new_weight, gemm_select
    );
endinterface

// File: rtl/spad_req_decoder.sv
// Pops scratchpad request words and turns each into a stream of per-row
// scratchpad requests (load/store) or a single systolic-array command (gemm).
module spad_req_decoder #(
    parameter int ROWS  = 4,
    parameter int IDX_W = $clog2(ROWS)
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                flush,
    spad_req_decoder_if.master  bus,
    output logic                busy,
    output logic                bad_op,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_ROW     = 2'd2,
        S_GEMM    = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_GEMM  = 2'b11;

    state_t            state_q, state_d;
    logic              load_q, load_d;
    logic [3:0]        matrix_q, matrix_d;
    logic [31:0]       base_q, base_d;
    logic [4:0]        stride_q, stride_d;
    logic [IDX_W-1:0]  row_idx_q, row_idx_d;
    logic              bad_op_q, bad_op_d;

    logic              row_last_w;
    logic [31:0]       row_addr_w;

    assign row_last_w = (row_idx_q == IDX_W'(ROWS - 1));
    // Stride is in 32-bit words; the sum wraps modulo 2^32 by design.
    assign row_addr_w = base_q + ((32'(stride_q) << 2) * 32'(row_idx_q));

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        matrix_d  = matrix_q;
        base_d    = base_q;
        stride_d  = stride_q;
        row_idx_d = row_idx_q;
        bad_op_d  = 1'b0;

        bus.fifo_ren   = 1'b0;
        bus.row_valid  = 1'b0;
        bus.gemm_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.fifo_empty && !flush && nRST) begin
                    bus.fifo_ren = 1'b1;
                    state_d      = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                load_d    = (bus.fifo_rdata[42:41] == OP_LOAD);
                matrix_d  = bus.fifo_rdata[40:37];
                base_d    = bus.fifo_rdata[36:5];
                stride_d  = bus.fifo_rdata[4:0];
                row_idx_d = '0;
                case (bus.fifo_rdata[42:41])
                    OP_LOAD, OP_STORE: state_d = S_ROW;
                    OP_GEMM:           state_d = S_GEMM;
                    default: begin
                        state_d  = S_IDLE;
                        bad_op_d = 1'b1;
                    end
                endcase
            end
            S_ROW: begin
                bus.row_valid = 1'b1;
                if (bus.row_ready) begin
                    row_idx_d = row_idx_q + 1'b1;
                    if (row_last_w) state_d = S_IDLE;
                end
            end
            S_GEMM: begin
                bus.gemm_valid = 1'b1;
                if (bus.gemm_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A word captured during flush is dropped, so it must not report bad_op.
        if (flush) begin
            state_d  = S_IDLE;
            bad_op_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            load_q    <= 1'b0;
            matrix_q  <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            row_idx_q <= '0;
            bad_op_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            matrix_q  <= matrix_d;
            base_q    <= base_d;
            stride_q  <= stride_d;
            row_idx_q <= row_idx_d;
            bad_op_q  <= bad_op_d;
        end
    end

    // Payloads read zero outside their own state so idle outputs are quiet.
    always_comb begin
        bus.row_load        = (state_q == S_ROW) ? load_q     : 1'b0;
        bus.row_matrix      = (state_q == S_ROW) ? matrix_q   : 4'd0;
        bus.row_idx         = (state_q == S_ROW) ? row_idx_q  : '0;
        bus.row_addr        = (state_q == S_ROW) ? row_addr_w : 32'd0;
        bus.row_last        = (state_q == S_ROW) && row_last_w;
        bus.gemm_new_weight = (state_q == S_GEMM) ? matrix_q[3]   : 1'b0;
        bus.gemm_select     = (state_q == S_GEMM) ? base_q[15:0]  : 16'd0;
    end

    assign busy      = (state_q != S_IDLE);
    assign bad_op    = bad_op_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spad_req_decoder.sv
// Directed bench for spad_req_decoder: FIFO model, row/gemm scoreboards and
// handshake stability checks on every cycle.
module tb_spad_req_decoder;
  localparam int ROWS  = 4;
  localparam int IDX_W = $clog2(ROWS);
  localparam int RW    = 38 + IDX_W;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       flush = 1'b0;
  logic       busy, bad_op;
  logic [1:0] dbg_state;

  spad_req_decoder_if #(.ROWS(ROWS)) bus ();

  spad_req_decoder #(.ROWS(ROWS)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .flush     (flush),
    .bus       (bus.master),
    .busy      (busy),
    .bad_op    (bad_op),
    .dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int bad_cnt = 0;

  logic [42:0]   fifo_q[$];
  logic [RW-1:0] exp_q[$];
  logic [16:0]   gexp_q[$];

  logic          row_prev_stall = 1'b0;
  logic          gem_prev_stall = 1'b0;
  logic          flush_prev = 1'b0;
  logic [RW-1:0] row_prev = '0;
  logic [16:0]   gem_prev = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({bus.fifo_ren, bus.row_valid, bus.row_load, bus.row_matrix, bus.row_idx,
                bus.row_addr, bus.row_last, bus.gemm_valid, bus.gemm_new_weight,
                bus.gemm_select, busy, bad_op});
  endfunction

  function automatic logic [RW-1:0] cur_row();
    return {bus.row_load, bus.row_matrix, bus.row_idx, bus.row_addr, bus.row_last};
  endfunction

  task automatic push_mem(input logic [1:0] op, input logic [3:0] mat, input logic [31:0] addr,
                          input logic [4:0] stride, input bit expect_rows);
    fifo_q.push_back({op, mat, addr, stride});
    bus.fifo_empty = 1'b0;
    if (expect_rows) begin
      for (int i = 0; i < ROWS; i++) begin
        logic [31:0] a;
        a = addr + 32'(i) * 32'(stride) * 32'd4;
        exp_q.push_back({op == 2'b01, mat, IDX_W'(i), a, i == ROWS - 1});
      end
    end
  endtask

  task automatic push_gemm(input logic nw, input logic [15:0] sel);
    fifo_q.push_back({2'b11, nw, 3'b010, 16'hA5A5, sel, 5'd17});
    bus.fifo_empty = 1'b0;
    gexp_q.push_back({nw, sel});
  endtask

  task automatic push_bad();
    fifo_q.push_back({2'b00, 4'h9, 32'h1234_5678, 5'd3});
    bus.fifo_empty = 1'b0;
  endtask

  // One clock: checks handshakes/stability before the edge, then models the FIFO.
  task automatic cyc();
    logic ren_s;
    logic [RW-1:0] r;
    r = cur_row();
    if (row_prev_stall && !flush_prev)
      chk("row_hold", {bus.row_valid, r}, {1'b1, row_prev});
    if (gem_prev_stall && !flush_prev)
      chk("gemm_hold", {bus.gemm_valid, bus.gemm_new_weight, bus.gemm_select}, {1'b1, gem_prev});
    chk("valid_excl", bus.row_valid && bus.gemm_valid, 0);
    if (bus.row_valid && bus.row_ready) begin
      if (exp_q.size() == 0) chk("row_unexpected", 1, 0);
      else chk("row_sb", r, exp_q.pop_front());
    end
    if (bus.gemm_valid && bus.gemm_ready) begin
      if (gexp_q.size() == 0) chk("gemm_unexpected", 1, 0);
      else chk("gemm_sb", {bus.gemm_new_weight, bus.gemm_select}, gexp_q.pop_front());
    end
    if (bad_op) bad_cnt++;
    row_prev_stall = bus.row_valid && !bus.row_ready;
    row_prev       = r;
    gem_prev_stall = bus.gemm_valid && !bus.gemm_ready;
    gem_prev       = {bus.gemm_new_weight, bus.gemm_select};
    flush_prev     = flush;
    ren_s          = bus.fifo_ren;
    @(posedge CLK);
    #1;
    if (ren_s) begin
      if (fifo_q.size() > 0) begin
        bus.fifo_rdata = fifo_q.pop_front();
        pops++;
      end else chk("pop_empty", 1, 0);
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;
    bus.row_ready  = 1'b0;
    bus.gemm_ready = 1'b0;

    // Reset held with a word waiting: nothing may move.
    push_mem(2'b01, 4'd3, 32'h0000_1000, 5'd4, 1'b1);
    repeat (3) begin
      #1;
      chk("rst_outs", out_vec(), 0);
      chk("rst_state", dbg_state, 0);
      cyc();
    end

    // Load, always ready.
    bus.row_ready = 1'b1;
    nRST = 1'b1;
    #1;
    chk("ld_pop", bus.fifo_ren, 1);
    cyc();
    chk("ld_capture", {busy, bus.row_valid, bus.fifo_ren}, 3'b100);
    cyc();
    for (int i = 0; i < ROWS; i++) begin
      chk("ld_valid", bus.row_valid, 1);
      chk("ld_load", bus.row_load, 1);
      chk("ld_matrix", bus.row_matrix, 3);
      chk("ld_last", bus.row_last, i == ROWS - 1);
      chk("ld_addr", bus.row_addr, 32'h1000 + 32'(i) * 32'h10);
      cyc();
    end
    chk("ld_done", {busy, bus.row_valid}, 0);

    // Store with backpressure and address wrap; a gemm waits behind it.
    push_mem(2'b10, 4'd5, 32'hFFFF_FFF8, 5'd1, 1'b1);
    #1;
    chk("st_pop", bus.fifo_ren, 1);
    cyc();
    push_gemm(1'b1, 16'hBEEF);
    bus.gemm_ready = 1'b0;
    #1;
    chk("st_capture_ren", bus.fifo_ren, 0);
    cyc();
    chk("st_addr0", bus.row_addr, 32'hFFFF_FFF8);
    chk("st_load", bus.row_load, 0);
    cyc();
    bus.row_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("st_stall_valid", bus.row_valid, 1);
      chk("st_stall_addr", bus.row_addr, 32'hFFFF_FFFC);
      chk("st_stall_idx", bus.row_idx, 1);
      chk("st_stall_ren", bus.fifo_ren, 0);
      cyc();
    end
    bus.row_ready = 1'b1;
    #1;
    chk("st_addr1", bus.row_addr, 32'hFFFF_FFFC);
    cyc();
    chk("st_addr2", bus.row_addr, 32'h0000_0000);
    chk("st_ren2", bus.fifo_ren, 0);
    cyc();
    chk("st_addr3", bus.row_addr, 32'h0000_0004);
    chk("st_last3", bus.row_last, 1);
    cyc();

    // GEMM with gemm_ready delayed two cycles.
    chk("gm_pop", {busy, bus.fifo_ren}, 2'b01);
    cyc();
    cyc();
    repeat (2) begin
      chk("gm_stall", {bus.gemm_valid, bus.gemm_new_weight, bus.gemm_select, bus.row_valid},
          {1'b1, 1'b1, 16'hBEEF, 1'b0});
      cyc();
    end
    bus.gemm_ready = 1'b1;
    #1;
    chk("gm_accept", {bus.gemm_valid, bus.gemm_new_weight, bus.gemm_select}, {1'b1, 1'b1, 16'hBEEF});
    cyc();
    chk("gm_done", {busy, bus.gemm_valid}, 0);

    // Reserved op followed by a stride-0 load.
    push_bad();
    push_mem(2'b01, 4'd7, 32'h2000_0000, 5'd0, 1'b1);
    #1;
    chk("bad_pop", bus.fifo_ren, 1);
    cyc();
    chk("bad_capture", {busy, bad_op}, 2'b10);
    cyc();
    chk("bad_pulse", bad_op, 1);
    chk("bad_busy", busy, 0);
    chk("bad_next_pop", bus.fifo_ren, 1);
    cyc();
    chk("bad_once", {bad_op, busy}, 2'b01);
    cyc();
    for (int i = 0; i < ROWS; i++) begin
      chk("s0_addr", {bus.row_valid, bus.row_addr, bus.row_matrix}, {1'b1, 32'h2000_0000, 4'd7});
      cyc();
    end
    chk("s0_done", busy, 0);

    // Flush in CAPTURE: the popped word is dropped, the next one runs.
    push_mem(2'b01, 4'd1, 32'h0000_0100, 5'd2, 1'b0);
    push_mem(2'b10, 4'd2, 32'h0000_0300, 5'd3, 1'b1);
    #1;
    chk("fl_pop", bus.fifo_ren, 1);
    cyc();
    flush = 1'b1;
    #1;
    chk("fl_cap_ren", bus.fifo_ren, 0);
    cyc();
    chk("fl_cap_idle", {busy, bus.row_valid, bus.gemm_valid, bad_op}, 0);
    flush = 1'b0;
    #1;
    chk("fl_cap_repop", bus.fifo_ren, 1);
    cyc();
    cyc();
    chk("fl_row0", bus.row_addr, 32'h0000_0300);
    cyc();
    chk("fl_row1", bus.row_addr, 32'h0000_030C);
    cyc();

    // Flush at row 2 with a gemm queued behind.
    push_gemm(1'b0, 16'h1234);
    flush = 1'b1;
    bus.row_ready = 1'b0;
    #1;
    chk("fl_row2", {bus.row_valid, bus.row_idx}, {1'b1, IDX_W'(2)});
    chk("fl_row_ren", bus.fifo_ren, 0);
    cyc();
    chk("fl_row_drop", {bus.row_valid, busy}, 0);
    chk("fl_row_left", exp_q.size(), 2);
    exp_q.delete();
    flush = 1'b0;
    bus.row_ready = 1'b1;
    #1;
    chk("fl_row_repop", bus.fifo_ren, 1);
    cyc();
    cyc();
    chk("fl_gemm", {bus.gemm_valid, bus.gemm_new_weight, bus.gemm_select, bus.row_valid},
        {1'b1, 1'b0, 16'h1234, 1'b0});
    cyc();
    chk("fl_no_resume", {busy, bus.row_valid}, 0);

    // Asynchronous reset in the middle of a row stream.
    push_mem(2'b01, 4'd4, 32'h0000_4000, 5'd8, 1'b1);
    #1;
    cyc();
    cyc();
    cyc();
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_outs", out_vec(), 0);
    chk("arst_state", dbg_state, 0);
    chk("arst_left", exp_q.size(), 3);
    exp_q.delete();
    row_prev_stall = 1'b0;
    cyc();
    #2;
    nRST = 1'b1;
    #1;
    chk("arst_idle", {busy, bus.fifo_ren}, 0);

    // Recovery: a gemm after reset completes within a bounded wait.
    push_gemm(1'b1, 16'h00FF);
    #1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!busy && gexp_q.size() == 0) break;
    end
    chk("rec_timeout", {busy, 32'(gexp_q.size())}, 0);

    chk("sb_rows_empty", exp_q.size(), 0);
    chk("bad_count", bad_cnt, 1);
    chk("pop_count", pops, 10);
    chk("fifo_drained", fifo_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
